// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package addsub_pkg;

  // Operation encoding on the op input.
  localparam logic ADDSUB_OP_ADD = 1'b0;
  localparam logic ADDSUB_OP_SUB = 1'b1;

  // Bit positions inside the registered flag vector.
  localparam int FLG_COUT = 0;
  localparam int FLG_OVF  = 1;
  localparam int FLG_ZERO = 2;
  localparam int FLG_NEG  = 3;
  localparam int FLG_W    = 4;

  // Widest result sat_value can describe; callers truncate to their width.
  localparam int SAT_MAX_W = 64;

  // Clamp value for a signed overflow: an overflow with a negative A can only
  // have gone below the minimum, and one with a positive A only above the maximum.
  function automatic logic [SAT_MAX_W-1:0] sat_value(input logic msb, input int width);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i == width - 1) begin
        v[i] = msb;
      end else if (i < width - 1) begin
        v[i] = ~msb;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// One carry-chain segment: SEG-bit ripple of full-adder cells, with B
// inverted for subtraction. Also exposes the carry into the MSB cell so the
// final segment can detect signed overflow.
module addsub_seg
  import addsub_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           op_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o,
  output logic           cmsb_o
);

  logic [SEG-1:0] bx;

  assign bx = (op_i == ADDSUB_OP_SUB) ? ~b_i : b_i;

  // Ripple the carry through SEG full-adder cells, LSB first.
  always_comb begin
    logic c;
    c      = cin_i;
    cmsb_o = 1'b0;
    sum_o  = '0;
    for (int i = 0; i < SEG; i++) begin
      if (i == SEG - 1) begin
        cmsb_o = c;
      end
      sum_o[i] = a_i[i] ^ bx[i] ^ c;
      c        = (a_i[i] & bx[i]) | (c & (a_i[i] ^ bx[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor. The carry chain is cut into
// STAGES segments; stage k adds segment k and registers its carry for stage
// k+1. Operand bits not yet consumed travel forward with the carry, finished
// result bits travel forward below them (skewed pipeline). The last stage
// also applies saturation and registers the result and flags. A single
// advance signal stalls the whole pipe when the consumer is not ready.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SEG = WIDTH / STAGES;

  logic             adv;
  logic             last_vld;
  logic [WIDTH-1:0] s_d;
  logic [FLG_W-1:0] flags_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic [FLG_W-1:0] flags_q;

  // Bubbles are not squeezed out: the pipe moves as a whole or not at all.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LW = k * SEG;      // result bits already finished
    localparam int UW = WIDTH - LW;   // operand bits still to be added

    logic [UW-1:0]     a_in;
    logic [UW-1:0]     b_in;
    logic              cin_in;
    logic              op_in;
    logic              sat_in;
    logic              vld_in;
    logic [SEG-1:0]    seg_sum;
    logic              seg_cout;
    logic              seg_cmsb;
    logic [LW+SEG-1:0] sum_lo_nxt;

    if (k == 0) begin : g_src
      assign a_in       = a;
      assign b_in       = b;
      assign cin_in     = op;
      assign op_in      = op;
      assign sat_in     = sat;
      assign vld_in     = in_valid;
      assign sum_lo_nxt = seg_sum;
    end else begin : g_src
      assign a_in       = g_stage[k-1].g_reg.a_q;
      assign b_in       = g_stage[k-1].g_reg.b_q;
      assign cin_in     = g_stage[k-1].g_reg.c_q;
      assign op_in      = g_stage[k-1].g_reg.op_q;
      assign sat_in     = g_stage[k-1].g_reg.sat_q;
      assign vld_in     = g_stage[k-1].g_reg.vld_q;
      assign sum_lo_nxt = {seg_sum, g_stage[k-1].g_reg.sum_q};
    end

    addsub_seg #(
      .SEG(SEG)
    ) u_seg (
      .a_i    (a_in[SEG-1:0]),
      .b_i    (b_in[SEG-1:0]),
      .op_i   (op_in),
      .cin_i  (cin_in),
      .sum_o  (seg_sum),
      .cout_o (seg_cout),
      .cmsb_o (seg_cmsb)
    );

    if (k < STAGES - 1) begin : g_reg
      logic [UW-SEG-1:0] a_q;
      logic [UW-SEG-1:0] b_q;
      logic [LW+SEG-1:0] sum_q;
      logic              c_q;
      logic              op_q;
      logic              sat_q;
      logic              vld_q;
      logic              unused_cmsb;

      // Only the top segment needs the MSB carry.
      assign unused_cmsb = seg_cmsb;

      // Slot-valid bit; cleared by reset so in-flight work is dropped.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
        end else if (adv) begin
          vld_q <= vld_in;
        end
      end

      // Carry, remaining operands, finished low result bits and controls move on.
      always_ff @(posedge clk) begin
        if (adv) begin
          a_q   <= a_in[UW-1:SEG];
          b_q   <= b_in[UW-1:SEG];
          sum_q <= sum_lo_nxt;
          c_q   <= seg_cout;
          op_q  <= op_in;
          sat_q <= sat_in;
        end
      end
    end else begin : g_out
      logic ovf_w;

      assign last_vld = vld_in;

      // Final result: carry into and out of the MSB differ exactly when
      // both operands share a sign the raw sum does not.
      always_comb begin
        ovf_w = seg_cmsb ^ seg_cout;
        s_d   = sum_lo_nxt;
        if (sat_in && ovf_w) begin
          s_d = WIDTH'(sat_value(a_in[SEG-1], WIDTH));
        end
        flags_d           = '0;
        flags_d[FLG_COUT] = seg_cout ^ op_in;
        flags_d[FLG_OVF]  = ovf_w;
        flags_d[FLG_ZERO] = (s_d == '0);
        flags_d[FLG_NEG]  = s_d[WIDTH-1];
      end
    end
  end

  // Output register; result and flags only change when a valid op lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      out_valid_q <= last_vld;
      if (last_vld) begin
        s_q     <= s_d;
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = flags_q[FLG_COUT];
  assign ovf       = flags_q[FLG_OVF];
  assign zero      = flags_q[FLG_ZERO];
  assign neg       = flags_q[FLG_NEG];

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed corner cases, reset and backpressure on a
// 16/4 instance, and random streams on 16/4, 8/1 and 32/8 instances, all
// scored against an integer-arithmetic reference model.
module tb_addsub_pipe;
  import addsub_pkg::*;

  typedef struct {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  bit   lat_chk;
  bit   aux_go;
  int   out_cnt;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, s;
  logic        op, sat, cout, ovf, zero, neg;
  logic [3:0]  flags_w;
  exp_t        q[$];
  bit          stall_prev;
  logic [15:0] held_s;
  logic [3:0]  held_f;

  assign flags_w = {neg, zero, ovf, cout};

  addsub_pipe #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: signed integer sum/difference, then range check and clamp.
  function automatic exp_t model(input logic [63:0] ia, input logic [63:0] ib,
                                 input logic iop, input logic isat, input int w);
    exp_t e;
    logic signed [63:0] span, maxv, minv, sa, sb, r;
    logic [63:0] mask, ua, ub;
    span = 64'sd1 <<< w;
    mask = $unsigned(span - 64'sd1);
    ua   = ia & mask;
    ub   = ib & mask;
    maxv = (span >>> 1) - 64'sd1;
    minv = -(span >>> 1);
    sa   = (ua > $unsigned(maxv)) ? $signed(ua) - span : $signed(ua);
    sb   = (ub > $unsigned(maxv)) ? $signed(ub) - span : $signed(ub);
    r    = iop ? sa - sb : sa + sb;
    e.ovf = (r > maxv) || (r < minv);
    if (isat && e.ovf) r = (r > maxv) ? maxv : minv;
    e.s    = $unsigned(r) & mask;
    e.cout = iop ? (ua < ub) : ((ua + ub) > mask);
    e.zero = (e.s == 64'd0);
    e.neg  = e.s[w-1];
    e.cyc  = 0;
    e.lat  = 1'b1;
    return e;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 6))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard for the 16/4 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_s", s, held_s);
        check("hold_flags", flags_w, held_f);
      end
      stall_prev = out_valid && !out_ready;
      held_s = s;
      held_f = flags_w;
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        out_cnt++;
        if (q.size() == 0) begin
          check("stale_out", out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          check("s", s, e.s);
          check("flags", flags_w, {e.neg, e.zero, e.ovf, e.cout});
          if (e.lat) check("latency", cyc, e.cyc + 4);
        end
      end
      if (in_valid && in_ready) begin
        e = model(a, b, op, sat, 16);
        e.cyc = cyc;
        e.lat = lat_chk;
        q.push_back(e);
      end
    end
  end

  task automatic put(input logic [15:0] ia, input logic [15:0] ib, input logic iop, input logic isat);
    int n;
    n = 0;
    a = ia; b = ib; op = iop; sat = isat; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("put_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic get_out(output logic [15:0] rs, output logic [3:0] rf);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 32) begin
      @(negedge clk);
      n++;
    end
    check("get_timeout", out_valid, 1'b1);
    rs = s;
    rf = flags_w;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Random streams on the other two parameter sets, out_ready held high.
  for (genvar g = 0; g < 2; g++) begin : g_aux
    localparam int W = (g == 0) ? 8 : 32;
    localparam int S = (g == 0) ? 1 : 8;
    logic         xin_valid, xin_ready, xout_valid, xout_ready;
    logic [W-1:0] xa, xb, xs;
    logic         xop, xsat, xcout, xovf, xzero, xneg;
    logic         done;
    exp_t         xq[$];

    addsub_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(xin_valid), .in_ready(xin_ready),
      .a(xa), .b(xb), .op(xop), .sat(xsat), .out_valid(xout_valid), .out_ready(xout_ready),
      .s(xs), .cout(xcout), .ovf(xovf), .zero(xzero), .neg(xneg)
    );

    initial begin
      done = 1'b0; xin_valid = 1'b0; xout_ready = 1'b1;
      xa = '0; xb = '0; xop = 1'b0; xsat = 1'b0;
      wait (aux_go);
      @(posedge clk);
      #1;
      for (int i = 0; i < 1000; i++) begin
        xa = W'($urandom); xb = W'($urandom);
        xop = 1'($urandom); xsat = 1'($urandom);
        xin_valid = 1'b1;
        @(posedge clk);
        #1;
      end
      xin_valid = 1'b0;
      for (int n = 0; n < 64 && xq.size() != 0; n++) @(posedge clk);
      done = 1'b1;
    end

    always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
        xq.delete();
      end else begin
        if (xout_valid && xout_ready) begin
          if (xq.size() == 0) begin
            check("x_stale_out", xout_valid, 1'b0);
          end else begin
            e = xq.pop_front();
            check("x_s", 64'(xs), e.s);
            check("x_flags", {xneg, xzero, xovf, xcout}, {e.neg, e.zero, e.ovf, e.cout});
            check("x_latency", cyc, e.cyc + S);
          end
        end
        if (xin_valid && xin_ready) begin
          e = model(64'(xa), 64'(xb), xop, xsat, W);
          e.cyc = cyc;
          xq.push_back(e);
        end
      end
    end
  end

  initial begin
    logic [15:0] rs;
    logic [3:0]  rf;
    int          base;
    int          n;
    cyc = 0; checks = 0; errors = 0; out_cnt = 0;
    lat_chk = 1'b1; aux_go = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = ADDSUB_OP_ADD; sat = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_s", s, 16'h0);
    check("rst_flags", flags_w, 4'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Cross-segment carry
    put(16'h00FF, 16'h0001, ADDSUB_OP_ADD, 1'b0);
    get_out(rs, rf);
    check("carry_seg_s", rs, 16'h0100);
    put(16'hFFFF, 16'h0001, ADDSUB_OP_ADD, 1'b0);
    get_out(rs, rf);
    check("wrap_s", rs, 16'h0000);
    check("wrap_flags", rf, 4'b0101);

    // Subtract with and without borrow
    put(16'h0003, 16'h0005, ADDSUB_OP_SUB, 1'b0);
    get_out(rs, rf);
    check("borrow_s", rs, 16'hFFFE);
    check("borrow_flags", rf, 4'b1001);
    put(16'h0005, 16'h0003, ADDSUB_OP_SUB, 1'b0);
    get_out(rs, rf);
    check("noborrow_s", rs, 16'h0002);
    check("noborrow_flags", rf, 4'b0000);

    // Overflow, raw and saturated
    put(16'h7FFF, 16'h0001, ADDSUB_OP_ADD, 1'b0);
    get_out(rs, rf);
    check("ovf_raw_s", rs, 16'h8000);
    check("ovf_raw_flags", rf, 4'b1010);
    put(16'h7FFF, 16'h0001, ADDSUB_OP_ADD, 1'b1);
    get_out(rs, rf);
    check("sat_max_s", rs, 16'h7FFF);
    check("sat_max_flags", rf, 4'b0010);
    put(16'h8000, 16'h0001, ADDSUB_OP_SUB, 1'b1);
    get_out(rs, rf);
    check("sat_min_s", rs, 16'h8000);
    check("sat_min_flags", rf, 4'b1010);

    // Reset with three ops in flight; nothing may come out afterwards
    for (int i = 0; i < 3; i++) put(rnd16(), rnd16(), 1'($urandom), 1'($urandom));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("postrst_out_valid", out_valid, 1'b0);
    check("postrst_s", s, 16'h0);
    check("postrst_flags", flags_w, 4'h0);
    @(posedge clk);
    #1;

    // Backpressure: 8 back-to-back ops, consumer stalls for cycles 5..9
    lat_chk = 1'b0;
    base = out_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) put(rnd16(), rnd16(), 1'($urandom), 1'($urandom));
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", out_cnt - base, 8);
    lat_chk = 1'b1;

    // Throughput: 1000 random back-to-back ops
    base = out_cnt;
    for (int i = 0; i < 1000; i++) put(rnd16(), rnd16(), 1'($urandom), 1'($urandom));
    drain();
    check("rand_count", out_cnt - base, 1000);

    // Other parameter sets
    aux_go = 1'b1;
    n = 0;
    while (!(g_aux[0].done && g_aux[1].done) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("aux_done", {g_aux[1].done, g_aux[0].done}, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
